// File: rtl/ghost_dir_picker.sv
// Ghost direction picker: draws random legal headings without reversing,
// falling back to a fixed priority pick after MAX_TRIES rejected draws.
module ghost_dir_picker #(
  parameter int MAX_TRIES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_random,
  input  logic       i_req,
  input  logic [3:0] i_legal,
  input  logic [1:0] i_cur_dir,
  output logic [1:0] o_dir,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_stuck
);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t     state_q, state_d;
  logic [3:0] try_q, try_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] cur_q, cur_d;
  logic       stuck_pend_q, stuck_pend_d;
  logic [1:0] dir_d;
  logic       valid_d, stuck_d;

  logic [3:0] rev_onehot, excl_mask, new_mask;
  logic [1:0] cand, fallback;

  assign rev_onehot = 4'b0001 << (i_cur_dir ^ 2'd2);
  assign excl_mask  = i_legal & ~rev_onehot;
  // Reversing is only allowed when it is the one remaining way out.
  assign new_mask   = (excl_mask != 4'b0000) ? excl_mask : i_legal;
  assign cand       = i_random[1:0];
  assign o_busy     = (state_q == DRAW);

  always_comb begin
    fallback = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i]) fallback = 2'(i);
    end
  end

  // NOTE: every signal gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d      = state_q;
    try_d        = try_q;
    mask_d       = mask_q;
    cur_d        = cur_q;
    stuck_pend_d = stuck_pend_q;
    dir_d        = o_dir;
    valid_d      = 1'b0;
    stuck_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (stuck_pend_q) begin
          // Requests arriving while a stuck report is pending are dropped.
          valid_d      = 1'b1;
          stuck_d      = 1'b1;
          dir_d        = cur_q;
          stuck_pend_d = 1'b0;
        end else if (i_req) begin
          cur_d  = i_cur_dir;
          mask_d = new_mask;
          if (i_legal == 4'b0000) begin
            stuck_pend_d = 1'b1;
          end else begin
            state_d = DRAW;
            try_d   = 4'd0;
          end
        end
      end
      DRAW: begin
        if (mask_q[cand]) begin
          dir_d   = cand;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (try_q == 4'(MAX_TRIES - 1)) begin
          dir_d   = fallback;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          try_d = try_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      try_q        <= 4'd0;
      mask_q       <= 4'd0;
      cur_q        <= 2'd0;
      stuck_pend_q <= 1'b0;
      o_dir        <= 2'd0;
      o_valid      <= 1'b0;
      o_stuck      <= 1'b0;
    end else begin
      state_q      <= state_d;
      try_q        <= try_d;
      mask_q       <= mask_d;
      cur_q        <= cur_d;
      stuck_pend_q <= stuck_pend_d;
      o_dir        <= dir_d;
      o_valid      <= valid_d;
      o_stuck      <= stuck_d;
    end
  end

endmodule

// File: doc/ghost_dir_picker.md
GHOST_DIR_PICKER -- requirements
Module: ghost_dir_picker

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 8, legal range 1..15: maximum random draws per request before fallback.
REQ-002 SHALL have port i_clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_random, input, 4: free-running value from the team's LFSR random source; only bits [1:0] are used.
REQ-005 SHALL have port i_req, input, 1: one-cycle request for a new direction.
REQ-006 SHALL have port i_legal, input, 4: legal-move mask; bit0 up, bit1 left, bit2 down, bit3 right.
REQ-007 SHALL have port i_cur_dir, input, 2: current heading, encoded 0 up, 1 left, 2 down, 3 right.
REQ-008 SHALL have port o_dir, output, 2: chosen direction, same encoding as i_cur_dir.
REQ-009 SHALL have port o_valid, output, 1: one-cycle pulse; o_dir/o_stuck are valid in this cycle.
REQ-010 SHALL have port o_busy, output, 1: high while a request is in progress.
REQ-011 SHALL have port o_stuck, output, 1: set with o_valid when no legal move exists.

Function
REQ-012 SHALL implement FSM states IDLE, DRAW; o_valid is registered.
REQ-013 In IDLE with i_req=1, SHALL latch i_legal and i_cur_dir and compute eff_mask = i_legal & ~onehot(i_cur_dir ^ 2) (no reversal).
REQ-014 If eff_mask==0 and i_legal!=0, SHALL use eff_mask = i_legal, so reversal is allowed only as the sole option.
REQ-015 If latched i_legal==0, SHALL stay in IDLE and, next cycle, pulse o_valid with o_stuck=1 and o_dir=latched i_cur_dir.
REQ-016 Otherwise SHALL go to DRAW, clear the 4-bit try counter, and assert o_busy from the next cycle.
REQ-017 Each DRAW cycle SHALL test cand = i_random[1:0]; if eff_mask[cand]=1, SHALL register o_dir=cand, pulse o_valid the next cycle, and return to IDLE.
REQ-018 On a rejected draw, SHALL increment the try counter.
REQ-019 When a rejected draw occurs with the try counter at MAX_TRIES-1, SHALL select the fallback instead: lowest-index set bit of eff_mask (priority up, left, down, right), with identical valid timing.
REQ-020 Latency: request to o_valid SHALL be 2 cycles minimum and MAX_TRIES+1 cycles maximum.
REQ-021 i_req while o_busy=1 SHALL be ignored; i_req in the same cycle o_valid is high SHALL be accepted, since the FSM is in IDLE.
REQ-022 Changes on i_legal or i_cur_dir during DRAW SHALL have no effect.
REQ-023 o_dir SHALL hold its last value between o_valid pulses.
REQ-024 o_stuck SHALL be 0 whenever o_valid=0.
REQ-025 o_busy SHALL be low in IDLE and high in DRAW.

Reset
REQ-026 On i_rst_n=0, SHALL asynchronously force state IDLE, try counter 0, o_dir=0, o_valid=0, o_busy=0, o_stuck=0.
REQ-027 Reset during DRAW SHALL abort the request with no o_valid pulse; the request is lost.
REQ-028 After reset release, the first i_req edge SHALL be serviced normally.

Verification
REQ-029 Accept first draw: i_legal=4'b1111, i_cur_dir=0, i_random=4'h1 at req -> o_valid 2 cycles after req, o_dir=1, o_stuck=0.
REQ-030 Reverse excluded: i_legal=4'b0101, i_cur_dir=0, i_random cycles 2,2,0 -> o_valid on 4th cycle, o_dir=0; candidate 2 is never accepted.
REQ-031 Reverse sole option: i_legal=4'b0100, i_cur_dir=0, i_random=2 -> o_dir=2, o_valid 2 cycles after req.
REQ-032 Fallback: MAX_TRIES=8, i_legal=4'b1010, i_cur_dir=1, i_random held 0 -> o_valid exactly 9 cycles after req, o_dir=1 (eff_mask=4'b0010); o_busy high for 8 cycles.
REQ-033 Stuck: i_legal=0, i_cur_dir=3 -> o_valid 2 cycles after req, o_stuck=1, o_dir=3, o_busy never high.
REQ-034 Abort/ignore: i_rst_n low for 1 cycle during DRAW -> all outputs 0, no o_valid; a second i_req during busy -> no extra o_valid.
